// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
// Takes a length-prefixed byte stream (16-bit word count, high byte first,
// then big-endian words) and writes consecutive words starting at BASE_ADDR.
// The CPU is held until the last word has been committed.
//
// state  | meaning
// -------+-----------------------------------------------------------
// LEN_HI | waiting for high byte of the word count
// LEN_LO | waiting for low byte of the word count; decides next step
// DATA   | collecting the four bytes of the current word
// WRITE  | single-cycle memory write of the assembled word
// DONE   | load complete, CPU released, stream ignored
// ERR    | word count exceeded MAX_WORDS, CPU held until reset
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byteIn,
    input  logic        byteValid,
    output logic        byteReady,
    output logic [31:0] memAddr,
    output logic [31:0] memDIn,
    output logic        memWe,
    output logic        cpuHold,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t      state;
    logic [15:0] count;
    logic [15:0] wordIdx;
    logic [1:0]  byteCnt;
    logic [23:0] shiftReg;   // first three bytes of the word in flight

    logic        accept;
    logic [15:0] lenFull;

    assign accept  = byteValid && byteReady;
    assign lenFull = {count[15:8], byteIn};

    // Status outputs decoded purely from the state register
    assign byteReady = (state == LEN_HI) || (state == LEN_LO) || (state == DATA);
    assign cpuHold   = (state != DONE);
    assign done      = (state == DONE);
    assign err       = (state == ERR);

    // Loader FSM with registered memory write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= LEN_HI;
            count    <= 16'd0;
            wordIdx  <= 16'd0;
            byteCnt  <= 2'd0;
            shiftReg <= 24'd0;
            memAddr  <= BASE_ADDR;
            memDIn   <= 32'd0;
            memWe    <= 1'b0;
        end else begin
            memWe <= 1'b0;
            case (state)
                LEN_HI: begin
                    if (accept) begin
                        count[15:8] <= byteIn;
                        state       <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        count[7:0] <= byteIn;
                        if (lenFull == 16'd0) begin
                            state <= DONE;
                        end else if (32'(lenFull) > MAX_WORDS) begin
                            state <= ERR;
                        end else begin
                            state   <= DATA;
                            byteCnt <= 2'd0;
                            wordIdx <= 16'd0;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        shiftReg <= {shiftReg[15:0], byteIn};
                        byteCnt  <= byteCnt + 2'd1;
                        if (byteCnt == 2'd3) begin
                            state   <= WRITE;
                            memWe   <= 1'b1;
                            memDIn  <= {shiftReg, byteIn};
                            memAddr <= BASE_ADDR + {14'd0, wordIdx, 2'b00};
                        end
                    end
                end
                WRITE: begin
                    if (wordIdx + 16'd1 == count) begin
                        state <= DONE;
                    end else begin
                        wordIdx <= wordIdx + 16'd1;
                        state   <= DATA;
                    end
                end
                default: begin
                    // DONE and ERR are terminal until reset
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: drives two loaders (default parameters, and BASE_ADDR=0x100
// with MAX_WORDS=4) from one shared byte stream and checks both against a
// byte-count based reference model plus a final expected write list.
module tb_imem_loader;

    typedef logic [7:0] bq_t[$];

    logic        clk;
    logic        reset;
    logic [7:0]  byteIn;
    logic        byteValid;
    logic        rdy[2];
    logic [31:0] addr[2];
    logic [31:0] dat[2];
    logic        we[2];
    logic        hold[2];
    logic        dn[2];
    logic        er[2];

    int total = 0;
    int bad   = 0;

    // per-DUT reference model state
    int          acc[2];
    int          nW[2];
    logic [7:0]  hiB[2];
    logic        expWe[2];
    int          expPulses[2];
    logic [31:0] capA0[$], capD0[$], capA1[$], capD1[$];

    imem_loader dut0 (
        .clk(clk), .reset(reset), .byteIn(byteIn), .byteValid(byteValid),
        .byteReady(rdy[0]), .memAddr(addr[0]), .memDIn(dat[0]), .memWe(we[0]),
        .cpuHold(hold[0]), .done(dn[0]), .err(er[0])
    );

    imem_loader #(.BASE_ADDR(32'h0000_0100), .MAX_WORDS(4)) dut1 (
        .clk(clk), .reset(reset), .byteIn(byteIn), .byteValid(byteValid),
        .byteReady(rdy[1]), .memAddr(addr[1]), .memDIn(dat[1]), .memWe(we[1]),
        .cpuHold(hold[1]), .done(dn[1]), .err(er[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int maxw(input int d);
        return (d == 0) ? 1024 : 4;
    endfunction

    function automatic logic [31:0] baseOf(input int d);
        return (d == 0) ? 32'h0 : 32'h100;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", tag, act, exp);
        end
    endtask

    // Per-cycle model: expected memWe and status from accepted-byte counts
    task automatic monitor(input int d);
        logic xDone, xErr;
        int   k;
        if (reset) begin
            acc[d] = 0; nW[d] = 0; hiB[d] = 8'd0; expWe[d] = 1'b0; expPulses[d] = 0;
            return;
        end
        xDone = (acc[d] >= 2) && (nW[d] == 0 ||
                (nW[d] <= maxw(d) && expPulses[d] == nW[d] && !expWe[d]));
        xErr  = (acc[d] >= 2) && (nW[d] > maxw(d));
        check($sformatf("d%0d.memWe", d),     32'(we[d]),   32'(expWe[d]));
        check($sformatf("d%0d.done", d),      32'(dn[d]),   32'(xDone));
        check($sformatf("d%0d.err", d),       32'(er[d]),   32'(xErr));
        check($sformatf("d%0d.cpuHold", d),   32'(hold[d]), 32'(!xDone));
        check($sformatf("d%0d.byteReady", d), 32'(rdy[d]),  32'(!(xDone || xErr || expWe[d])));
        if (we[d] === 1'b1) begin
            if (d == 0) begin capA0.push_back(addr[d]); capD0.push_back(dat[d]); end
            else        begin capA1.push_back(addr[d]); capD1.push_back(dat[d]); end
        end
        expWe[d] = 1'b0;
        if (byteValid && rdy[d]) begin
            if (acc[d] == 0) begin
                hiB[d] = byteIn;
            end else if (acc[d] == 1) begin
                nW[d] = int'({hiB[d], byteIn});
            end else begin
                k = acc[d] - 2;
                if (k % 4 == 3 && k / 4 < nW[d] && nW[d] <= maxw(d)) begin
                    expWe[d] = 1'b1;
                    expPulses[d]++;
                end
            end
            acc[d]++;
        end
    endtask

    always @(negedge clk) begin
        monitor(0);
        monitor(1);
    end

    task automatic clearCaps();
        capA0.delete(); capD0.delete(); capA1.delete(); capD1.delete();
    endtask

    // Expected writes: each complete word within a legal count
    task automatic compareWrites(input int d, input bq_t s);
        logic [31:0] ea[$], ed[$], ca[$], cd[$];
        int n;
        n = (s.size() >= 2) ? int'({s[0], s[1]}) : 0;
        if (n != 0 && n <= maxw(d)) begin
            for (int i = 0; i < n && 2 + 4 * i + 3 < s.size(); i++) begin
                ea.push_back(baseOf(d) + 32'(4 * i));
                ed.push_back({s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]});
            end
        end
        if (d == 0) begin ca = capA0; cd = capD0; end
        else        begin ca = capA1; cd = capD1; end
        check($sformatf("d%0d.nWrites", d), 32'(ca.size()), 32'(ea.size()));
        for (int i = 0; i < ea.size() && i < ca.size(); i++) begin
            check($sformatf("d%0d.addr[%0d]", d, i), ca[i], ea[i]);
            check($sformatf("d%0d.data[%0d]", d, i), cd[i], ed[i]);
        end
    endtask

    task automatic checkResetVals();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d.rst.memWe", d),     32'(we[d]),   32'd0);
            check($sformatf("d%0d.rst.cpuHold", d),   32'(hold[d]), 32'd1);
            check($sformatf("d%0d.rst.done", d),      32'(dn[d]),   32'd0);
            check($sformatf("d%0d.rst.err", d),       32'(er[d]),   32'd0);
            check($sformatf("d%0d.rst.byteReady", d), 32'(rdy[d]),  32'd1);
            check($sformatf("d%0d.rst.memAddr", d),   addr[d],      baseOf(d));
            check($sformatf("d%0d.rst.memDIn", d),    dat[d],       32'd0);
        end
    endtask

    // Called in the phase just after a rising edge
    task automatic doReset();
        byteValid = 1'b0;
        reset     = 1'b1;
        #1;
        checkResetVals();
        clearCaps();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic sendBytes(input bq_t s, input bit bubbles);
        int  waitc;
        bit  got;
        for (int i = 0; i < s.size(); i++) begin
            byteIn = s[i];
            got    = 1'b0;
            waitc  = 0;
            while (!got && waitc < 50) begin
                byteValid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
                @(negedge clk);
                if (byteValid && rdy[0]) got = 1'b1;
                @(posedge clk);
                #1;
                waitc++;
            end
            if (!got) begin
                check("byteTimeout", 32'(got), 32'd1);
                break;
            end
        end
        byteValid = 1'b0;
    endtask

    task automatic idle(input int n);
        byteValid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic junk(input int n);
        repeat (n) begin
            byteValid = 1'b1;
            byteIn    = 8'($urandom);
            @(posedge clk);
            #1;
        end
        byteValid = 1'b0;
    endtask

    function automatic bq_t mkStream(input int n, input bit rnd);
        bq_t q;
        q.push_back(8'(n >> 8));
        q.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            for (int b = 3; b >= 0; b--)
                q.push_back(rnd ? 8'($urandom) : 8'((i + 1) >> (8 * b)));
        end
        return q;
    endfunction

    initial begin
        bq_t s, part;
        byteValid = 1'b0;
        byteIn    = 8'd0;
        reset     = 1'b1;
        #1;
        checkResetVals();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // single word, valid held high, then post-done ignore
        s = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        sendBytes(s, 1'b0);
        idle(3);
        compareWrites(0, s);
        compareWrites(1, s);
        junk(20);
        idle(2);
        compareWrites(0, s);
        compareWrites(1, s);

        // three words with random bubbles
        doReset();
        s = mkStream(3, 1'b0);
        sendBytes(s, 1'b1);
        idle(3);
        compareWrites(0, s);
        compareWrites(1, s);

        // zero count
        doReset();
        s = '{8'h00, 8'h00};
        sendBytes(s, 1'b0);
        idle(3);
        junk(5);
        compareWrites(0, s);
        compareWrites(1, s);

        // count 1025: error on both
        doReset();
        s = '{8'h04, 8'h01};
        sendBytes(s, 1'b0);
        idle(2);
        junk(16);
        idle(2);
        compareWrites(0, s);
        compareWrites(1, s);

        // reset after the sixth data byte of a two-word load
        doReset();
        s = mkStream(2, 1'b1);
        part = s[0:7];
        sendBytes(part, 1'b0);
        idle(1);
        compareWrites(0, part);
        compareWrites(1, part);
        doReset();
        s = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        sendBytes(s, 1'b0);
        idle(3);
        compareWrites(0, s);
        compareWrites(1, s);

        // random streams; first two hit MAX_WORDS and MAX_WORDS+1 on dut1
        for (int it = 0; it < 8; it++) begin
            doReset();
            s = mkStream((it < 2) ? 4 + it : int'($urandom_range(1, 6)), 1'b1);
            sendBytes(s, 1'($urandom_range(0, 1)));
            idle(3);
            compareWrites(0, s);
            compareWrites(1, s);
        end

        // full MAX_WORDS load on dut0
        doReset();
        s = mkStream(1024, 1'b1);
        sendBytes(s, 1'b0);
        idle(3);
        compareWrites(0, s);
        compareWrites(1, s);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes instruction memory, the writer side of the fetch path that `cpu2` reads. It accepts a length-prefixed byte stream over a valid/ready handshake, assembles big-endian 32-bit words and writes them to consecutive word addresses. While it loads, it holds the CPU. On completion it releases the CPU so the CPU fetches from address 0.

## Interface

Parameters:
- `BASE_ADDR`, default 0: byte address of the first word written. Must be word-aligned.
- `MAX_WORDS`, default 1024: largest accepted word count. A larger count is an error.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `byteIn`  in  8  stream byte.
- `byteValid`  in  1  `byteIn` is valid.
- `byteReady`  out  1  loader can accept a byte this cycle.
- `memAddr`  out  32  write byte address, word-aligned.
- `memDIn`  out  32  write data.
- `memWe`  out  1  write enable, one-cycle pulse per word.
- `cpuHold`  out  1  1 = CPU held (PC frozen at 0).
- `done`  out  1  load completed; sticky until reset.
- `err`  out  1  word count > `MAX_WORDS`; sticky until reset.

## Operation

- **Stream format:**
  - 16-bit word count N, high byte first.
  - Then 4·N data bytes.
  - Each word is big-endian: the first byte goes to `memDIn[31:24]`, the last to `[7:0]`.
- **Byte acceptance:** a byte is accepted on a rising edge where `byteValid && byteReady`. `byteIn` is ignored otherwise.
- **States:** LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR. The reset state is LEN_HI.
- **LEN_HI:** `byteReady`=1. On accept, latch `count[15:8]` and go to LEN_LO.
- **LEN_LO:** `byteReady`=1. On accept, latch `count[7:0]`. The next state is decided on the full 16-bit value:
  - N=0 → DONE.
  - N>`MAX_WORDS` → ERR.
  - Otherwise → DATA, with byte counter = 0 and word index = 0.
- **DATA:** `byteReady`=1.
  - Each accept shifts the byte into the word assembly register and increments the 2-bit byte counter.
  - The accept with byte counter = 3 moves to WRITE; the counter wraps to 0.
- **WRITE:** lasts exactly one cycle, with `byteReady`=0.
  - `memWe`=1, `memAddr` = `BASE_ADDR` + 4·wordIdx, `memDIn` = assembled word.
  - Next: wordIdx+1 == N → DONE; otherwise wordIdx increments and the state returns to DATA.
- **DONE:** `byteReady`=0, `cpuHold`=0, `done`=1. Further bytes are ignored and never written.
- **ERR:** `byteReady`=0, `cpuHold`=1, `err`=1, `memWe`=0. The loader stays here until reset.
- **Index and address width:**
  - wordIdx is 16 bits.
  - Address arithmetic is 32-bit unsigned; wrap-around is impossible for legal `MAX_WORDS`.
- **Output registering:**
  - `memAddr`, `memDIn` and `memWe` are registered.
  - `byteReady`, `cpuHold`, `done` and `err` are decoded from the state register. They are glitch-free, with no input-to-output combinational path.

## Timing

- **Reset values** (applied asynchronously while `reset`=1):
  - State LEN_HI.
  - `byteReady`=1. No byte is accepted while `reset`=1.
  - `cpuHold`=1, `done`=0, `err`=0, `memWe`=0.
  - `memAddr`=`BASE_ADDR`, `memDIn`=0.
  - count=0, wordIdx=0, byte counter=0.
- **Write latency:** `memWe` is high in the cycle immediately after the edge that accepts the 4th byte of a word.
  - `memAddr` and `memDIn` are valid in that same cycle.
  - `memWe` is never high two consecutive cycles.
- **Throughput:** at most one word per 5 cycles (4 accepts + 1 WRITE). `byteValid` may stay high continuously.
- **Release:** `cpuHold` falls and `done` rises in the cycle after the final WRITE cycle, or in the cycle after the LEN_LO accept when N=0. The last write is therefore committed to memory before the CPU leaves hold.
- **Stalled source:** with `byteValid`=0 the loader waits indefinitely in any accepting state. Partial words and counts are preserved.
- **Reset mid-load:**
  - The partial word and count are discarded.
  - `cpuHold` returns to 1 immediately.
  - Words already written remain in memory.
  - The next stream byte after reset release is treated as `count[15:8]`.
- **Boundary cases:**
  - N = `MAX_WORDS` is accepted.
  - N = `MAX_WORDS`+1 → ERR; no write ever occurs.

## Test plan

- **Single word:** stream 00 01 DE AD BE EF with `byteValid` held high → exactly one `memWe` pulse with `memAddr`=0x00000000, `memDIn`=0xDEADBEEF, in the cycle after byte 6. `done`=1 and `cpuHold`=0 one cycle later; `byteReady`=0 thereafter.
- **Multi-word with bubbles:** N=3, words 0x00000001/0x00000002/0x00000003, `byteValid` toggled randomly → writes to addresses 0x0, 0x4, 0x8 in order with matching data. Exactly 3 pulses, each ≥5 cycles apart.
- **Zero and error counts:**
  - Stream 00 00 → `done`=1 with no `memWe`.
  - After reset, with `MAX_WORDS`=1024, stream 04 01 → `err`=1, `cpuHold`=1, `byteReady`=0; then 16 further bytes produce no writes.
- **Reset mid-word:** N=2, reset asserted after the 6th data byte → outputs return to reset values immediately. A fresh stream 00 01 11 22 33 44 writes 0x11223344 to address 0x0.
- **BASE_ADDR:** `BASE_ADDR`=0x100, N=2 → writes to 0x100 and 0x104.
- **Post-done ignore:** after `done`, drive `byteValid`=1 for 20 cycles → no `memWe`, and `done`/`cpuHold` are unchanged.
